// File: rtl/lamp_move_sequencer_if.sv
// Button-to-lamp move bus.
//   slave  : sequencer side (takes raw buttons, drives moves and status)
//   master : driver/observer side (drives raw buttons, observes moves and status)
// Signals:
//   btn_up/btn_down/btn_left/btn_right : raw asynchronous buttons, active-high
//   up/down/left/right                 : one-hot move, only during the en cycle
//   en                                 : one-cycle step strobe
//   busy, overflow, queue_count        : status
interface lamp_move_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          btn_up;
  logic          btn_down;
  logic          btn_left;
  logic          btn_right;
  logic          up;
  logic          down;
  logic          left;
  logic          right;
  logic          en;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] queue_count;

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right,
    output up, down, left, right, en, busy, overflow, queue_count
  );

  modport master (
    output btn_up, btn_down, btn_left, btn_right,
    input  up, down, left, right, en, busy, overflow, queue_count
  );
endinterface

// File: rtl/lamp_move_sequencer.sv
// Front-end controller for the 4-bit lamp state machine.
// Synchronises and debounces four direction buttons, turns rising debounced
// levels into press events, arbitrates them (up > down > left > right) into a
// small FIFO of 2-bit move codes and issues one move at a time as a one-hot
// direction plus a single-cycle en strobe, followed by a fixed idle gap.
// Ports:
//   clk : system clock, rising edge
//   clr : synchronous active-low reset
//   bus : lamp_move_sequencer_if.slave (buttons in; moves, en, busy,
//         overflow, queue_count out)
module lamp_move_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  lamp_move_sequencer_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    st_idle,
    st_issue,
    st_gap
  } state_t;

  // Bit index equals the move code: up=0, down=1, left=2, right=3.
  logic [3:0] raw;
  logic [3:0] db_level;
  assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  // Per-button synchroniser and debouncer: db_level follows sync only after
  // DEBOUNCE_CYCLES consecutive edges on which the two disagree.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic          sync_reg;
      logic          db_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!clr) begin
          sync_reg <= 1'b0;
          db_reg   <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          sync_reg <= raw[gi];
          if (sync_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
            db_reg  <= sync_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign db_level[gi] = db_reg;
    end
  endgenerate

  logic [3:0]    db_prev_reg;
  logic [3:0]    pending_reg, pending_next;
  logic          overflow_reg, overflow_next;
  logic [3:0]    press;
  logic [3:0]    grant;
  logic [1:0]    grant_code;
  logic          push, pop, issue, full;

  logic [1:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;

  state_t        state_reg, state_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [3:0]    move_reg, move_next;

  assign press = db_level & ~db_prev_reg;
  assign full  = (count_reg == CW'(FIFO_DEPTH));
  assign push  = |grant;

  // Fixed-priority pick; scanning downwards leaves the lowest index (up) last
  // so it wins. Nothing is granted while the FIFO is full.
  always_comb begin
    grant      = 4'b0000;
    grant_code = 2'b00;
    if (!full) begin
      for (int i = 3; i >= 0; i--) begin
        if (pending_reg[i]) begin
          grant      = 4'b0001 << i;
          grant_code = 2'(i);
        end
      end
    end
  end

  // A press on a button whose previous press is still waiting is merged into
  // the pending bit and flagged as lost.
  always_comb begin
    pending_next  = (pending_reg & ~grant) | press;
    overflow_next = overflow_reg | (|(press & pending_reg));
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Issue FSM: one en cycle, then GAP_CYCLES idle cycles before the next.
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    pop        = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      st_idle: begin
        if (count_reg != '0) begin
          state_next = st_issue;
          issue      = 1'b1;
        end
      end
      st_issue: begin
        pop        = 1'b1;
        gap_next   = GW'(GAP_CYCLES - 1);
        state_next = st_gap;
      end
      st_gap: begin
        if (gap_reg == '0) begin
          if (count_reg != '0) begin
            state_next = st_issue;
            issue      = 1'b1;
          end else begin
            state_next = st_idle;
          end
        end else begin
          gap_next = gap_reg - GW'(1);
        end
      end
      default: state_next = st_idle;
    endcase
  end

  // The head is captured on the edge entering ISSUE, so the direction lines
  // come straight from a register and are zero in every other cycle.
  always_comb begin
    move_next = 4'b0000;
    if (issue) begin
      move_next = 4'b0001 << fifo_mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= grant_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      db_prev_reg  <= 4'b0000;
      pending_reg  <= 4'b0000;
      overflow_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      state_reg    <= st_idle;
      gap_reg      <= '0;
      move_reg     <= 4'b0000;
    end else begin
      db_prev_reg  <= db_level;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg    <= count_next;
      state_reg    <= state_next;
      gap_reg      <= gap_next;
      move_reg     <= move_next;
    end
  end

  assign bus.en          = (state_reg == st_issue);
  assign bus.up          = move_reg[0];
  assign bus.down        = move_reg[1];
  assign bus.left        = move_reg[2];
  assign bus.right       = move_reg[3];
  assign bus.busy        = (state_reg != st_idle) || (count_reg != '0);
  assign bus.overflow    = overflow_reg;
  assign bus.queue_count = count_reg;
endmodule

// File: tb/tb_lamp_move_sequencer.sv
// Testbench for lamp_move_sequencer: directed scenarios plus randomized
// button activity, checked every cycle against a timestamp/queue model.
module tb_lamp_move_sequencer;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 8;

  logic clk;
  logic clr_a;
  logic clr_b;
  int   chk_cnt;
  int   err_cnt;

  lamp_move_sequencer_if #(.FIFO_DEPTH(DEPTH)) if_a ();
  lamp_move_sequencer_if #(.FIFO_DEPTH(DEPTH)) if_b ();

  lamp_move_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)
  ) dut_a (
    .clk(clk), .clr(clr_a), .bus(if_a)
  );

  lamp_move_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(100)
  ) dut_b (
    .clk(clk), .clr(clr_b), .bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic [3:0] v);
    if_a.btn_up    = v[0];
    if_a.btn_down  = v[1];
    if_a.btn_left  = v[2];
    if_a.btn_right = v[3];
  endtask

  task automatic set_b(input logic [3:0] v);
    if_b.btn_up    = v[0];
    if_b.btn_down  = v[1];
    if_b.btn_left  = v[2];
    if_b.btn_right = v[3];
  endtask

  function automatic logic [3:0] dirs_a();
    return {if_a.right, if_a.left, if_a.down, if_a.up};
  endfunction

  function automatic logic [3:0] dirs_b();
    return {if_b.right, if_b.left, if_b.down, if_b.up};
  endfunction

  // ---------------- reference model for dut_a ----------------
  // Debounce as "level flips after DEB consecutive disagreeing samples";
  // issue timing as "next en no earlier than GAP+1 edges after the last one".
  int m_sync[4], m_db[4], m_dbp[4], m_run[4], m_pend[4];
  int m_ovf, m_en, m_dir, m_last, m_cyc;
  int m_q[$];
  bit m_started;

  task automatic model_step();
    int raw[4];
    int ev[4];
    int g;
    int issue;
    raw[0] = if_a.btn_up;
    raw[1] = if_a.btn_down;
    raw[2] = if_a.btn_left;
    raw[3] = if_a.btn_right;
    m_cyc++;
    m_started = 1'b1;
    if (!clr_a) begin
      for (int i = 0; i < 4; i++) begin
        m_sync[i] = 0; m_db[i] = 0; m_dbp[i] = 0; m_run[i] = 0; m_pend[i] = 0;
      end
      m_ovf = 0; m_en = 0; m_dir = 0; m_last = -1000000;
      m_q.delete();
      return;
    end
    for (int i = 0; i < 4; i++) ev[i] = (m_db[i] != 0 && m_dbp[i] == 0) ? 1 : 0;
    g = -1;
    if (m_q.size() < DEPTH) begin
      for (int i = 3; i >= 0; i--) if (m_pend[i] != 0) g = i;
    end
    issue = (m_en == 0 && m_q.size() > 0 && (m_cyc - m_last) >= GAP + 1) ? 1 : 0;
    if (m_en != 0) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back(g);
    for (int i = 0; i < 4; i++) if (ev[i] != 0 && m_pend[i] != 0) m_ovf = 1;
    if (g >= 0) m_pend[g] = 0;
    for (int i = 0; i < 4; i++) if (ev[i] != 0) m_pend[i] = 1;
    for (int i = 0; i < 4; i++) begin
      m_dbp[i] = m_db[i];
      if (m_sync[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] >= DEB) begin
          m_db[i]  = m_sync[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_sync[i] = raw[i];
    end
    m_en = issue;
    if (issue != 0) begin
      m_last = m_cyc;
      m_dir  = m_q[0];
    end
  endtask

  task automatic model_compare();
    int busy;
    busy = (m_en != 0 || (m_cyc - m_last) <= GAP || m_q.size() > 0) ? 1 : 0;
    check_eq("m_en", 32'(if_a.en), 32'(m_en));
    check_eq("m_dirs", 32'(dirs_a()), (m_en != 0) ? (32'd1 << m_dir) : 32'd0);
    check_eq("m_busy", 32'(if_a.busy), 32'(busy));
    check_eq("m_overflow", 32'(if_a.overflow), 32'(m_ovf));
    check_eq("m_queue_count", 32'(if_a.queue_count), 32'(m_q.size()));
  endtask

  initial begin
    m_started = 1'b0;
    m_cyc     = 0;
    m_last    = -1000000;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_started) model_compare();
    end
  end

  // Drive v on dut_a for `hold` edges starting at edge 0, observe n edges.
  task automatic run_a(input logic [3:0] v, input int hold, input int n,
                       output int first, output int second,
                       output logic [3:0] d1, output logic [3:0] d2,
                       output int ens, output int nbusy);
    first = -1; second = -1; d1 = 4'b0; d2 = 4'b0; ens = 0; nbusy = 0;
    set_a(v);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == hold - 1) set_a(4'b0000);
      if (if_a.busy || if_a.queue_count != 0) nbusy++;
      if (if_a.en) begin
        ens++;
        if (first < 0) begin
          first = k; d1 = dirs_a();
        end else if (second < 0) begin
          second = k; d2 = dirs_a();
        end
      end
    end
  endtask

  initial begin
    int first, second, ens, nbusy;
    logic [3:0] d1, d2;
    int b_edges[$];
    int b_ens, b_badd;
    int hold[4];
    logic [3:0] lvl;

    chk_cnt = 0;
    err_cnt = 0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    set_a(4'b0000);
    set_b(4'b0000);
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_en", 32'(if_a.en), 0);
    check_eq("rst_dirs", 32'(dirs_a()), 0);
    check_eq("rst_busy", 32'(if_a.busy), 0);
    check_eq("rst_overflow", 32'(if_a.overflow), 0);
    check_eq("rst_qc", 32'(if_a.queue_count), 0);
    check_eq("rst_b_en", 32'(if_b.en), 0);
    clr_a = 1'b1;
    clr_b = 1'b1;
    repeat (2) @(negedge clk);

    // Single up press
    run_a(4'b0001, 10, 40, first, second, d1, d2, ens, nbusy);
    check_eq("up_first_en_edge", 32'(first), 7);
    check_eq("up_dirs", 32'(d1), 32'b0001);
    check_eq("up_en_count", 32'(ens), 1);
    check_eq("up_busy_end", 32'(if_a.busy), 0);
    check_eq("up_qc_end", 32'(if_a.queue_count), 0);

    // Short glitch on left is filtered
    run_a(4'b0100, 3, 20, first, second, d1, d2, ens, nbusy);
    check_eq("glitch_en_count", 32'(ens), 0);
    check_eq("glitch_busy_cycles", 32'(nbusy), 0);

    // Simultaneous down+right: down first, right GAP+1 later
    run_a(4'b1010, 10, 40, first, second, d1, d2, ens, nbusy);
    check_eq("dr_first_edge", 32'(first), 7);
    check_eq("dr_first_dirs", 32'(d1), 32'b0010);
    check_eq("dr_spacing", 32'(second - first), 32'(GAP + 1));
    check_eq("dr_second_dirs", 32'(d2), 32'b1000);
    check_eq("dr_en_count", 32'(ens), 2);
    check_eq("dr_overflow", 32'(if_a.overflow), 0);

    // Reset during GAP with a move still queued
    set_a(4'b0011);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) set_a(4'b0000);
    end
    check_eq("rgap_qc_before", 32'(if_a.queue_count), 1);
    check_eq("rgap_busy_before", 32'(if_a.busy), 1);
    clr_a = 1'b0;
    @(negedge clk);
    check_eq("rgap_en", 32'(if_a.en), 0);
    check_eq("rgap_dirs", 32'(dirs_a()), 0);
    check_eq("rgap_busy", 32'(if_a.busy), 0);
    check_eq("rgap_qc", 32'(if_a.queue_count), 0);
    check_eq("rgap_overflow", 32'(if_a.overflow), 0);
    clr_a = 1'b1;
    run_a(4'b0000, 0, 20, first, second, d1, d2, ens, nbusy);
    check_eq("rgap_no_en_after", 32'(ens), 0);

    // Right held through a reset is a fresh press afterwards
    run_a(4'b1000, 1000, 30, first, second, d1, d2, ens, nbusy);
    check_eq("hold_pre_en_count", 32'(ens), 1);
    clr_a = 1'b0;
    @(negedge clk);
    clr_a = 1'b1;
    run_a(4'b1000, 12, 30, first, second, d1, d2, ens, nbusy);
    check_eq("hold_post_first_edge", 32'(first), 7);
    check_eq("hold_post_dirs", 32'(d1), 32'b1000);
    check_eq("hold_post_en_count", 32'(ens), 1);

    // dut_b (GAP 100): seven up presses, FIFO fills and one press is lost
    b_ens = 0;
    b_badd = 0;
    set_b(4'b0001);
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (if_b.en) begin
        b_edges.push_back(k);
        b_ens++;
        if (dirs_b() != 4'b0001) b_badd++;
      end
      if (k == 75) begin
        check_eq("gap100_qc_full", 32'(if_b.queue_count), 4);
        check_eq("gap100_overflow", 32'(if_b.overflow), 1);
      end
      set_b(((k + 1) < 70 && ((k + 1) % 10) < 5) ? 4'b0001 : 4'b0000);
    end
    check_eq("gap100_en_count", 32'(b_ens), 6);
    check_eq("gap100_bad_dirs", 32'(b_badd), 0);
    if (b_edges.size() > 0) check_eq("gap100_first_edge", 32'(b_edges[0]), 7);
    for (int i = 1; i < b_edges.size(); i++)
      check_eq("gap100_spacing", 32'(b_edges[i] - b_edges[i-1]), 101);
    check_eq("gap100_busy_end", 32'(if_b.busy), 0);

    // Randomized activity on dut_a, checked by the model every cycle
    for (int i = 0; i < 4; i++) hold[i] = 0;
    lvl = 4'b0000;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 14);
        end else begin
          hold[i]--;
        end
      end
      set_a(lvl);
      clr_a = ($urandom_range(0, 399) != 0);
    end
    set_a(4'b0000);
    clr_a = 1'b1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
